conv_fifo_in_controller: RTL and testbench
==========================================

CONV_FIFO_IN_CONTROLLER -- requirements
Module: conv_fifo_in_controller

Interface
REQ-001 Parameters SHALL be: SA_ROW_NUM=4 (FIFO rows); SA_COLUMN_NUM=3 (FIFO columns); PIXELS_IN_ROW_2POW=5 (log2 pixels per DDR row); OFS_IN_ROW_2POW=1 (log2 channel steps per DDR word); TAG_DEPTH=8 (max outstanding reads).
REQ-002 Ports SHALL be, in order:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- conv_fifo_in_start, in, 1: tile start pulse.
- ddr_en, in, 1: DDR read-request grant.
- input_ddr_layer_base_adr, in, 32: layer base word address.
- mode, in, 4: 0 selects 16-ch groups, 1 selects 32-ch groups.
- if_in_2pow, in, 4: log2 input channels.
- ix_in_2pow, in, 4: log2 input width.
- cur_ix_start, cur_iy_start, cur_if_start, cur_pix, cur_piy, cur_pif, in, 16 each: tile origin and extent, origins 1-based.
- ddr_rd_adr, out, 32: read address.
- ddr_rd_req, out, 1: read request, asserted only when ddr_en=1.
- ddr_rd_valid, in, 1: read-data strobe.
- ddr_rd_data, in, 512: read data.
- fifo_wrs, out, SA_ROW_NUM*SA_COLUMN_NUM: one-hot write strobes.
- fifo_wr_data, out, 512: FIFO write data.
- busy, out, 1: tile in progress.
- conv_fifo_in_tile_end, out, 1: single-cycle done pulse.
- rsp_err, out, 1: sticky error flag.
- stall_cnt, out, 32: stall counter.

Function
REQ-003 States SHALL be IDLE, ISSUE, DRAIN. IDLE->ISSUE on conv_fifo_in_start when mode is 0 or 1. Start is ignored in ISSUE and DRAIN, and ignored when mode>1.
REQ-004 Counters SHALL be iy_cnt (1..cur_piy) and w_cnt (0..ceil(cur_pif/2)-1), w innermost. Both SHALL advance only on an issued request.
REQ-005 Issue condition: ddr_rd_req = (state==ISSUE) && ddr_en && !tag_full. ddr_rd_req and ddr_rd_adr SHALL be combinational from the counters.
REQ-006 Read address SHALL be the sum of:
- input_ddr_layer_base_adr
- ((cur_iy_start-1+iy_cnt-1) << (if_in_2pow-1+ix_in_2pow-5))
- (((cur_ix_start-1) << (if_in_2pow-1)) >> 5)
- ((cur_if_start-1+2*w_cnt) >> 1)
All arithmetic SHALL be 32-bit unsigned, and wrap-around SHALL be ignored.
REQ-007 Destination FIFO index SHALL be (iy_cnt-1)*4 + ((2*w_cnt) >> L), where L=4 in mode 0 and L=5 in mode 1. The index SHALL be pushed with a last flag, set on the final word of the final row.
REQ-008 On the last issue, the block SHALL go ISSUE->DRAIN and reset the counters to w_cnt=0, iy_cnt=1.
REQ-009 ddr_rd_valid SHALL pop one tag. One cycle later, fifo_wrs[tag]=1 and fifo_wr_data=registered ddr_rd_data. Fixed latency: 1 cycle.
REQ-010 Pushing and popping in the same cycle SHALL leave the tag count unchanged. A push is allowed in the same cycle as a pop even when the queue is full.
REQ-011 ddr_rd_valid with the tag queue empty SHALL be dropped, write no FIFO, and set rsp_err (sticky until reset).
REQ-012 When the write carrying the last flag occurs, conv_fifo_in_tile_end SHALL pulse in that same cycle and the state SHALL go DRAIN->IDLE.
REQ-013 busy SHALL be 1 in ISSUE and in DRAIN.
REQ-014 Responses SHALL be assumed in-order. Out-of-order handling is not required.

Reset
REQ-015 Synchronous reset SHALL clear state to IDLE and counters to w_cnt=0, iy_cnt=1.
REQ-016 Synchronous reset SHALL also empty the tag queue and clear fifo_wrs, fifo_wr_data, ddr_rd_req, busy, conv_fifo_in_tile_end, rsp_err and stall_cnt.
REQ-017 Reset mid-tile SHALL discard outstanding tags. Later ddr_rd_valid responses SHALL be treated per REQ-011.

Configuration
REQ-018 Macro CONV_FIFO_IN_STALL_CNT_EN defined: stall_cnt SHALL increment every cycle with state==ISSUE && ddr_en && tag_full, saturating at 2^32-1.
REQ-019 Macro CONV_FIFO_IN_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-020 State encoding, mode constants (MODE_16CH=0, MODE_32CH=1) and log-channel values SHALL reside in shared package conv_ctrl_pkg.
REQ-021 The tag queue SHALL be sub-module conv_fifo_in_tag_queue: synchronous FIFO, width 5 (4-bit index + last), depth TAG_DEPTH, with full/empty outputs.

Verification
REQ-022 Mode 0 tile: cur_piy=3, cur_pif=64, all origins 1, if_in_2pow=6, ix_in_2pow=5, ddr_en=1, responses at 2-cycle latency -> 96 requests at addresses base+{0..31, 32..63, 64..95}, fifo_wrs index sequence 0,1,2,3 per row plus row offset 4, then one tile_end.
REQ-023 Mode 1 tile: cur_piy=1, cur_pif=64 -> words 0..15 go to FIFO 0 and words 16..31 go to FIFO 1.
REQ-024 Backpressure: responses withheld for 20 cycles -> exactly 8 requests issued, then ddr_rd_req=0; with the macro defined, stall_cnt=12.
REQ-025 Spurious ddr_rd_valid in IDLE -> no fifo_wrs activity and rsp_err=1.
REQ-026 Reset asserted after 5 requests -> all outputs 0 the next cycle, and a fresh start produces the full sequence from address base.
REQ-027 Start in ISSUE, or start with mode=2 -> ignored, and state and counters are unchanged.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared constants for the conv input controller: FSM encoding, channel-group modes,
// log2 channel sizes and the tag entry carried from request to response.
package conv_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] MODE_16CH = 4'd0;
  localparam logic [3:0] MODE_32CH = 4'd1;

  localparam logic [2:0] LOG_CH_16 = 3'd4;
  localparam logic [2:0] LOG_CH_32 = 3'd5;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
  } tag_t;

  // Each destination FIFO holds one channel group; this is log2 of its channel count.
  function automatic logic [2:0] mode_log_ch(input logic [3:0] mode);
    return (mode == MODE_32CH) ? LOG_CH_32 : LOG_CH_16;
  endfunction

endpackage

// File: rtl/conv_fifo_in_tag_queue.sv
// Synchronous FIFO of outstanding read tags; a push is accepted while full if a pop
// frees a slot in the same cycle.
module conv_fifo_in_tag_queue #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/conv_fifo_in_controller.sv
// Input-FIFO feeder for the conv array: walks a tile's rows and channel words, issues DDR
// reads and steers returned words to their FIFO. Optional stall counter: CONV_FIFO_IN_STALL_CNT_EN.
module conv_fifo_in_controller
  import conv_ctrl_pkg::*;
#(
  parameter int SA_ROW_NUM         = 4,
  parameter int SA_COLUMN_NUM      = 3,
  parameter int PIXELS_IN_ROW_2POW = 5,
  parameter int OFS_IN_ROW_2POW    = 1,
  parameter int TAG_DEPTH          = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                conv_fifo_in_start,
  input  logic                                ddr_en,
  input  logic [31:0]                         input_ddr_layer_base_adr,
  input  logic [3:0]                          mode,
  input  logic [3:0]                          if_in_2pow,
  input  logic [3:0]                          ix_in_2pow,
  input  logic [15:0]                         cur_ix_start,
  input  logic [15:0]                         cur_iy_start,
  input  logic [15:0]                         cur_if_start,
  input  logic [15:0]                         cur_pix,
  input  logic [15:0]                         cur_piy,
  input  logic [15:0]                         cur_pif,
  output logic [31:0]                         ddr_rd_adr,
  output logic                                ddr_rd_req,
  input  logic                                ddr_rd_valid,
  input  logic [511:0]                        ddr_rd_data,
  output logic [SA_ROW_NUM*SA_COLUMN_NUM-1:0] fifo_wrs,
  output logic [511:0]                        fifo_wr_data,
  output logic                                busy,
  output logic                                conv_fifo_in_tile_end,
  output logic                                rsp_err,
  output logic [31:0]                         stall_cnt
);

  localparam int NWR = SA_ROW_NUM * SA_COLUMN_NUM;

  logic [1:0]     r_state;
  logic [15:0]    r_iy_cnt;
  logic [15:0]    r_w_cnt;
  logic [NWR-1:0] r_fifo_wrs;
  logic [511:0]   r_fifo_wr_data;
  logic           r_tile_end;
  logic           r_rsp_err;

  logic [16:0] w_words;
  logic        w_w_last;
  logic        w_iy_last;
  logic        w_issue;
  logic        w_pop_ok;
  logic        w_tag_full;
  logic        w_tag_empty;
  logic        w_mode_ok;
  logic [31:0] w_row_shift;
  logic [31:0] w_row_term;
  logic [31:0] w_col_term;
  logic [31:0] w_ch_term;
  logic [31:0] w_grp;
  tag_t        w_push_tag;
  tag_t        w_head;
  logic        w_unused;

  assign w_unused = ^cur_pix;

  assign w_words   = (17'(cur_pif) + 17'd1) >> 1;
  assign w_w_last  = (17'(r_w_cnt) + 17'd1) >= w_words;
  assign w_iy_last = r_iy_cnt >= cur_piy;
  assign w_mode_ok = (mode == MODE_16CH) || (mode == MODE_32CH);
  assign w_issue   = (r_state == ST_ISSUE) && ddr_en && !w_tag_full;
  assign w_pop_ok  = ddr_rd_valid && !w_tag_empty;

  // Word address = layer base + row offset + column offset + channel-word offset.
  assign w_row_shift = 32'(if_in_2pow) + 32'(ix_in_2pow) - 32'd1 - 32'(PIXELS_IN_ROW_2POW);
  assign w_row_term  = (32'(cur_iy_start) - 32'd1 + 32'(r_iy_cnt) - 32'd1) << w_row_shift;
  assign w_col_term  = ((32'(cur_ix_start) - 32'd1) << (32'(if_in_2pow) - 32'd1)) >> PIXELS_IN_ROW_2POW;
  assign w_ch_term   = (32'(cur_if_start) - 32'd1 + (32'(r_w_cnt) << OFS_IN_ROW_2POW)) >> OFS_IN_ROW_2POW;

  assign ddr_rd_adr = input_ddr_layer_base_adr + w_row_term + w_col_term + w_ch_term;
  assign ddr_rd_req = w_issue;

  assign w_grp           = (32'(r_w_cnt) << OFS_IN_ROW_2POW) >> mode_log_ch(mode);
  assign w_push_tag.idx  = 4'(((32'(r_iy_cnt) - 32'd1) << 2) + w_grp);
  assign w_push_tag.last = w_w_last && w_iy_last;

  conv_fifo_in_tag_queue #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (w_issue),
    .push_data (w_push_tag),
    .pop       (ddr_rd_valid),
    .pop_data  (w_head),
    .full      (w_tag_full),
    .empty     (w_tag_empty)
  );

  // Channel word is the inner loop; the tile is done issuing after the last word of the last row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_iy_cnt <= 16'd1;
      r_w_cnt  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (conv_fifo_in_start && w_mode_ok) r_state <= ST_ISSUE;
        ST_ISSUE: begin
          if (w_issue) begin
            if (w_w_last) begin
              r_w_cnt <= 16'd0;
              if (w_iy_last) begin
                r_iy_cnt <= 16'd1;
                r_state  <= ST_DRAIN;
              end else begin
                r_iy_cnt <= r_iy_cnt + 16'd1;
              end
            end else begin
              r_w_cnt <= r_w_cnt + 16'd1;
            end
          end
        end
        ST_DRAIN: if (r_tile_end) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Responses arrive in order, so the queue head always names the destination FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_wrs     <= '0;
      r_fifo_wr_data <= '0;
      r_tile_end     <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_fifo_wrs <= w_pop_ok ? NWR'(32'd1 << w_head.idx) : '0;
      r_tile_end <= w_pop_ok && w_head.last;
      if (w_pop_ok) r_fifo_wr_data <= ddr_rd_data;
      if (ddr_rd_valid && w_tag_empty) r_rsp_err <= 1'b1;
    end
  end

`ifdef CONV_FIFO_IN_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_ISSUE) && ddr_en && w_tag_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

  assign fifo_wrs              = r_fifo_wrs;
  assign fifo_wr_data          = r_fifo_wr_data;
  assign conv_fifo_in_tile_end = r_tile_end;
  assign rsp_err               = r_rsp_err;
  assign busy                  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);

endmodule

// File: tb/tb_conv_fifo_in_controller.sv
// Randomized bench for conv_fifo_in_controller against a tile-level reference model.
// Honours CONV_FIFO_IN_STALL_CNT_EN when expecting the stall counter.
`timescale 1ns/1ps
module tb_conv_fifo_in_controller;

  localparam int NWR = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         conv_fifo_in_start;
  logic         ddr_en;
  logic [31:0]  input_ddr_layer_base_adr;
  logic [3:0]   mode;
  logic [3:0]   if_in_2pow;
  logic [3:0]   ix_in_2pow;
  logic [15:0]  cur_ix_start;
  logic [15:0]  cur_iy_start;
  logic [15:0]  cur_if_start;
  logic [15:0]  cur_pix;
  logic [15:0]  cur_piy;
  logic [15:0]  cur_pif;
  logic [31:0]  ddr_rd_adr;
  logic         ddr_rd_req;
  logic         ddr_rd_valid;
  logic [511:0] ddr_rd_data;
  logic [NWR-1:0] fifo_wrs;
  logic [511:0] fifo_wr_data;
  logic         busy;
  logic         conv_fifo_in_tile_end;
  logic         rsp_err;
  logic [31:0]  stall_cnt;

  always #5 clk = ~clk;

  conv_fifo_in_controller dut (
    .clk                      (clk),
    .reset                    (reset),
    .conv_fifo_in_start       (conv_fifo_in_start),
    .ddr_en                   (ddr_en),
    .input_ddr_layer_base_adr (input_ddr_layer_base_adr),
    .mode                     (mode),
    .if_in_2pow               (if_in_2pow),
    .ix_in_2pow               (ix_in_2pow),
    .cur_ix_start             (cur_ix_start),
    .cur_iy_start             (cur_iy_start),
    .cur_if_start             (cur_if_start),
    .cur_pix                  (cur_pix),
    .cur_piy                  (cur_piy),
    .cur_pif                  (cur_pif),
    .ddr_rd_adr               (ddr_rd_adr),
    .ddr_rd_req               (ddr_rd_req),
    .ddr_rd_valid             (ddr_rd_valid),
    .ddr_rd_data              (ddr_rd_data),
    .fifo_wrs                 (fifo_wrs),
    .fifo_wr_data             (fifo_wr_data),
    .busy                     (busy),
    .conv_fifo_in_tile_end    (conv_fifo_in_tile_end),
    .rsp_err                  (rsp_err),
    .stall_cnt                (stall_cnt)
  );

  typedef struct {
    logic [31:0] adr;
    int          idx;
    bit          last;
  } req_t;

  req_t expReq[$];
  req_t tagQ[$];
  int   respDue[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit rstReq, startReq, holdResp, forceValid;
  int enPct  = 100;
  int latMin = 2;
  int latMax = 2;

  bit             tileActive;
  bit             errModel;
  bit             expEnd;
  logic [NWR-1:0] expWrs;
  logic [511:0]   expData;
  logic [31:0]    stallModel;
  int reqSeen, wrSeen, endSeen;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full request list of a tile, straight from the address and FIFO-index rules.
  function automatic void buildTile();
    int words;
    words = (int'(cur_pif) + 1) / 2;
    expReq.delete();
    for (int r = 0; r < int'(cur_piy); r++) begin
      for (int w = 0; w < words; w++) begin
        req_t e;
        e.adr = input_ddr_layer_base_adr
              + ((32'(cur_iy_start) - 1 + 32'(r)) << (32'(if_in_2pow) - 1 + 32'(ix_in_2pow) - 5))
              + (((32'(cur_ix_start) - 1) << (32'(if_in_2pow) - 1)) >> 5)
              + ((32'(cur_if_start) - 1 + 32'(2 * w)) / 2);
        e.idx  = r * 4 + (2 * w) / ((mode == 4'd1) ? 32 : 16);
        e.last = (r == int'(cur_piy) - 1) && (w == words - 1);
        expReq.push_back(e);
      end
    end
  endfunction

  // One clock: drive inputs, compare everything, then advance the model across the edge.
  task automatic applyStimulus();
    bit           v;
    bit           issuing;
    bit           expReqOut;
    bit           startOk;
    bit           endNow;
    logic [511:0] d;
    req_t         t;
    @(negedge clk);
    cyc++;
    reset              = rstReq;
    conv_fifo_in_start = startReq;
    ddr_en             = ($urandom_range(99) < enPct);
    v = forceValid || (!rstReq && !holdResp && respDue.size() > 0 && respDue[0] <= cyc);
    if (v && !forceValid) void'(respDue.pop_front());
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    ddr_rd_valid = v;
    ddr_rd_data  = d;
    #1;
    checkOutput("fifo_wrs", fifo_wrs, expWrs);
    checkOutput("fifo_wr_data", fifo_wr_data, expData);
    checkOutput("tile_end", conv_fifo_in_tile_end, expEnd);
    checkOutput("busy", busy, tileActive);
    checkOutput("rsp_err", rsp_err, errModel);
    checkOutput("stall_cnt", stall_cnt, stallModel);
    if (fifo_wrs != '0) wrSeen++;
    if (conv_fifo_in_tile_end) endSeen++;
    issuing   = tileActive && expReq.size() > 0;
    expReqOut = issuing && ddr_en && tagQ.size() < 8;
    checkOutput("ddr_rd_req", ddr_rd_req, expReqOut);
    if (expReqOut) checkOutput("ddr_rd_adr", ddr_rd_adr, expReq[0].adr);

    if (rstReq) begin
      expReq.delete();
      tagQ.delete();
      respDue.delete();
      tileActive = 0;
      errModel   = 0;
      expEnd     = 0;
      expWrs     = '0;
      expData    = '0;
      stallModel = '0;
    end else begin
      endNow  = expEnd;
      startOk = startReq && !tileActive && (mode <= 4'd1);
`ifdef CONV_FIFO_IN_STALL_CNT_EN
      if (issuing && ddr_en && tagQ.size() == 8 && stallModel != 32'hFFFF_FFFF) stallModel++;
`endif
      expWrs = '0;
      expEnd = 0;
      if (v) begin
        if (tagQ.size() == 0) begin
          errModel = 1;
        end else begin
          t       = tagQ.pop_front();
          expWrs  = (t.idx < NWR) ? (NWR'(1) << t.idx) : '0;
          expData = d;
          expEnd  = t.last;
        end
      end
      if (expReqOut) begin
        t = expReq.pop_front();
        tagQ.push_back(t);
        respDue.push_back(cyc + int'($urandom_range(latMax, latMin)));
        reqSeen++;
      end
      if (endNow) tileActive = 0;
      if (startOk) begin
        tileActive = 1;
        buildTile();
      end
    end
  endtask

  task automatic setTile(input logic [31:0] base, input logic [3:0] md, input logic [3:0] ifp,
                         input logic [3:0] ixp, input logic [15:0] xs, input logic [15:0] ys,
                         input logic [15:0] fs, input logic [15:0] piy, input logic [15:0] pif);
    input_ddr_layer_base_adr = base;
    mode         = md;
    if_in_2pow   = ifp;
    ix_in_2pow   = ixp;
    cur_ix_start = xs;
    cur_iy_start = ys;
    cur_if_start = fs;
    cur_pix      = 16'd8;
    cur_piy      = piy;
    cur_pif      = pif;
  endtask

  task automatic finishTile(input int maxCyc);
    for (int i = 0; i < maxCyc && tileActive; i++) applyStimulus();
    checkOutput("tile_timeout", tileActive, 0);
  endtask

  task automatic runTile(input int maxCyc);
    reqSeen = 0; wrSeen = 0; endSeen = 0;
    startReq = 1;
    applyStimulus();
    startReq = 0;
    finishTile(maxCyc);
  endtask

  initial begin
    reset = 1; conv_fifo_in_start = 0; ddr_en = 0; ddr_rd_valid = 0; ddr_rd_data = '0;
    setTile(32'h0, 4'd0, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2);
    rstReq = 0; startReq = 0; holdResp = 0; forceValid = 0;
    tileActive = 0; errModel = 0; expEnd = 0; expWrs = '0; expData = '0; stallModel = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    applyStimulus();

    $display("[TB] mode 0 tile, 3 rows x 64 channels");
    setTile(32'h0000_1000, 4'd0, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd3, 16'd64);
    runTile(2000);
    checkOutput("m0_reqs", reqSeen, 96);
    checkOutput("m0_writes", wrSeen, 96);
    checkOutput("m0_tile_ends", endSeen, 1);

    $display("[TB] mode 1 tile, 1 row x 64 channels");
    setTile(32'h0000_2000, 4'd1, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd1, 16'd64);
    runTile(1000);
    checkOutput("m1_writes", wrSeen, 32);

    $display("[TB] backpressure with responses withheld");
    setTile(32'h0000_3000, 4'd0, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd3, 16'd64);
    holdResp = 1; reqSeen = 0; wrSeen = 0; endSeen = 0;
    startReq = 1;
    applyStimulus();
    startReq = 0;
    repeat (21) applyStimulus();
    checkOutput("bp_reqs", reqSeen, 8);
    checkOutput("bp_req_low", ddr_rd_req, 0);
`ifdef CONV_FIFO_IN_STALL_CNT_EN
    checkOutput("bp_stall", stall_cnt, 12);
`endif
    holdResp = 0;
    finishTile(2000);

    $display("[TB] spurious response while idle");
    forceValid = 1;
    applyStimulus();
    forceValid = 0;
    applyStimulus();
    checkOutput("spurious_err", rsp_err, 1);
    checkOutput("spurious_wrs", fifo_wrs, 0);
    rstReq = 1;
    applyStimulus();
    rstReq = 0;

    $display("[TB] reset after five requests");
    reqSeen = 0;
    startReq = 1;
    applyStimulus();
    startReq = 0;
    for (int i = 0; i < 200 && reqSeen < 5; i++) applyStimulus();
    checkOutput("rst_reqs", reqSeen, 5);
    rstReq = 1;
    applyStimulus();
    rstReq = 0;
    applyStimulus();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req", ddr_rd_req, 0);
    runTile(2000);
    checkOutput("rst_refill_reqs", reqSeen, 96);

    $display("[TB] ignored starts");
    setTile(32'h0000_4000, 4'd0, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd2, 16'd32);
    reqSeen = 0;
    startReq = 1;
    applyStimulus();
    startReq = 0;
    repeat (4) applyStimulus();
    startReq = 1;
    applyStimulus();
    startReq = 0;
    finishTile(1000);
    checkOutput("ign_reqs", reqSeen, 32);
    setTile(32'h0000_5000, 4'd2, 4'd6, 4'd5, 16'd1, 16'd1, 16'd1, 16'd2, 16'd32);
    runTile(10);
    applyStimulus();
    checkOutput("mode2_busy", busy, 0);
    checkOutput("mode2_reqs", reqSeen, 0);

    $display("[TB] random tiles");
    enPct = 70; latMin = 1; latMax = 4;
    for (int n = 0; n < 12; n++) begin
      setTile($urandom(), 4'($urandom_range(1)), 4'($urandom_range(7, 5)), 4'($urandom_range(7, 5)),
              16'($urandom_range(4, 1)), 16'($urandom_range(4, 1)), 16'($urandom_range(4, 1)),
              16'($urandom_range(3, 1)), 16'($urandom_range(64, 1)));
      runTile(3000);
      checkOutput("rnd_tile_end", endSeen, 1);
      repeat (3) applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
